seg7_card_decoder: RTL and testbench

Recovers card codes and baccarat hand scores from the six active-low 7-segment buses that drive the HEX0–HEX5 displays, performing the inverse of the card-to-segment encoding. Sits beside the display path as an on-chip monitor/scoreboard: it scans one digit per clock, accepts a digit only after repeated identical samples, and reports per-card codes, player/dealer scores and an invalid-pattern error.

---
 rtl/seg7_card_decoder.sv | 162 ++++++++++++++++
 tb/tb_seg7_card_decoder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seg7_card_decoder.sv
// Recovers card codes and baccarat scores from six active-low 7-segment buses.
// Optional invalid-pattern checking is enabled by defining SEG7DEC_ERRCHK_EN.
module seg7_card_decoder #(
    parameter int unsigned STABLE_CNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] HEX0,
    input  logic [6:0] HEX1,
    input  logic [6:0] HEX2,
    input  logic [6:0] HEX3,
    input  logic [6:0] HEX4,
    input  logic [6:0] HEX5,
    output logic [3:0] pcard1_out,
    output logic [3:0] pcard2_out,
    output logic [3:0] pcard3_out,
    output logic [3:0] dcard1_out,
    output logic [3:0] dcard2_out,
    output logic [3:0] dcard3_out,
    output logic [3:0] pscore_out,
    output logic [3:0] dscore_out,
    output logic       update,
    output logic       valid,
    output logic       err,
    output logic [2:0] err_digit
);

    localparam logic [3:0] STABLE = 4'(STABLE_CNT);

    logic [2:0] idx;
    logic [3:0] cand [0:5];
    logic [3:0] cnt  [0:5];
    logic [3:0] card [0:5];
    logic [5:0] seen;
    logic       card_chg;

    logic [6:0] sample;
    logic [3:0] code;
    logic [3:0] cnt_next;
    logic       accept;
    logic       changed;

    function automatic logic [3:0] decode(input logic [6:0] pat);
        case (pat)
            7'b1111111: decode = 4'd0;
            7'b0001000: decode = 4'd1;
            7'b0100100: decode = 4'd2;
            7'b0110000: decode = 4'd3;
            7'b0011001: decode = 4'd4;
            7'b0010010: decode = 4'd5;
            7'b0000010: decode = 4'd6;
            7'b1111000: decode = 4'd7;
            7'b0000000: decode = 4'd8;
            7'b0010000: decode = 4'd9;
            7'b1000000: decode = 4'd10;
            7'b1100001: decode = 4'd11;
            7'b0011000: decode = 4'd12;
            7'b0001001: decode = 4'd13;
`ifdef SEG7DEC_ERRCHK_EN
            default:    decode = 4'd15;
`else
            default:    decode = 4'd0;
`endif
        endcase
    endfunction

    function automatic logic [4:0] card_value(input logic [3:0] c);
        card_value = (c >= 4'd1 && c <= 4'd9) ? {1'b0, c} : 5'd0;
    endfunction

    function automatic logic [3:0] hand_score(input logic [3:0] c1, input logic [3:0] c2,
                                              input logic [3:0] c3);
        logic [4:0] sum;
        sum = card_value(c1) + card_value(c2) + card_value(c3);
        if (sum >= 5'd20)      sum = sum - 5'd20;
        else if (sum >= 5'd10) sum = sum - 5'd10;
        hand_score = sum[3:0];
    endfunction

    always_comb begin
        sample = '1;
        case (idx)
            3'd0:    sample = HEX0;
            3'd1:    sample = HEX1;
            3'd2:    sample = HEX2;
            3'd3:    sample = HEX3;
            3'd4:    sample = HEX4;
            3'd5:    sample = HEX5;
            default: sample = '1;
        endcase
    end

    // Acceptance fires on every sample whose count sits at STABLE; re-accepting
    // the same code is harmless because update only reports a value change.
    always_comb begin
        code     = decode(sample);
        cnt_next = 4'd1;
        if (code == cand[idx])
            cnt_next = (cnt[idx] >= STABLE) ? STABLE : cnt[idx] + 4'd1;
        accept  = (cnt_next == STABLE);
        changed = accept && (code != card[idx]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            seen     <= '0;
            card_chg <= 1'b0;
            for (int unsigned i = 0; i < 6; i++) begin
                cand[i] <= '0;
                cnt[i]  <= '0;
                card[i] <= '0;
            end
        end else begin
            idx       <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            cand[idx] <= code;
            cnt[idx]  <= cnt_next;
            card_chg  <= changed;
            if (accept) begin
                card[idx] <= code;
                seen[idx] <= 1'b1;
            end
        end
    end

`ifdef SEG7DEC_ERRCHK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err       <= 1'b0;
            err_digit <= '0;
        end else if (accept && code == 4'd15 && !err) begin
            err       <= 1'b1;
            err_digit <= idx;
        end
    end
`else
    assign err       = 1'b0;
    assign err_digit = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pscore_out <= '0;
            dscore_out <= '0;
            update     <= 1'b0;
            valid      <= 1'b0;
        end else begin
            pscore_out <= hand_score(card[0], card[1], card[2]);
            dscore_out <= hand_score(card[3], card[4], card[5]);
            update     <= card_chg;
            valid      <= (&seen) && !err;
        end
    end

    assign pcard1_out = card[0];
    assign pcard2_out = card[1];
    assign pcard3_out = card[2];
    assign dcard1_out = card[3];
    assign dcard2_out = card[4];
    assign dcard3_out = card[5];

endmodule

// File: tb/tb_seg7_card_decoder.sv
// Directed self-checking bench for seg7_card_decoder (default STABLE_CNT = 3).
module tb_seg7_card_decoder;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] P_A   = 7'b0001000;
    localparam logic [6:0] P_K   = 7'b0001001;
    localparam logic [6:0] P_7   = 7'b1111000;
    localparam logic [6:0] P_9   = 7'b0010000;
    localparam logic [6:0] P_5   = 7'b0010010;
    localparam logic [6:0] P_BAD = 7'b0101010;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] HEX0 = BLANK, HEX1 = BLANK, HEX2 = BLANK;
    logic [6:0] HEX3 = BLANK, HEX4 = BLANK, HEX5 = BLANK;
    logic [3:0] pcard1_out, pcard2_out, pcard3_out;
    logic [3:0] dcard1_out, dcard2_out, dcard3_out;
    logic [3:0] pscore_out, dscore_out;
    logic       update, valid, err;
    logic [2:0] err_digit;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;

    seg7_card_decoder #(.STABLE_CNT(3)) dut (
        .clk(clk), .reset(reset),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
        .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
        .pcard1_out(pcard1_out), .pcard2_out(pcard2_out), .pcard3_out(pcard3_out),
        .dcard1_out(dcard1_out), .dcard2_out(dcard2_out), .dcard3_out(dcard3_out),
        .pscore_out(pscore_out), .dscore_out(dscore_out),
        .update(update), .valid(valid), .err(err), .err_digit(err_digit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n cycles, sampling at the falling edge and counting update pulses.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (update) upd_cnt++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        upd_cnt = 0;
    endtask

    initial begin
        // Blank displays everywhere.
        do_reset();
        check("rst_valid", valid, 0);
        check("rst_err", err, 0);
        check("rst_err_digit", err_digit, 0);
        check("rst_pscore", pscore_out, 0);
        tick(18);
        check("blank_valid_c17", valid, 0);
        tick(1);
        check("blank_valid_c18", valid, 1);
        check("blank_pcard1", pcard1_out, 0);
        check("blank_dcard3", dcard3_out, 0);
        check("blank_dscore", dscore_out, 0);
        tick(10);
        check("blank_no_update", upd_cnt, 0);

        // Player A,K,7 ; dealer 9,9,blank.
        reset = 1'b1;
        HEX0 = P_A; HEX1 = P_K; HEX2 = P_7;
        HEX3 = P_9; HEX4 = P_9; HEX5 = BLANK;
        do_reset();
        tick(12);
        check("p1_before_accept", pcard1_out, 0);
        tick(1);
        check("p1_at_accept", pcard1_out, 1);
        tick(7);
        check("pcard1", pcard1_out, 1);
        check("pcard2", pcard2_out, 13);
        check("pcard3", pcard3_out, 7);
        check("dcard1", dcard1_out, 9);
        check("dcard2", dcard2_out, 9);
        check("dcard3", dcard3_out, 0);
        check("pscore", pscore_out, 8);
        check("dscore", dscore_out, 8);
        check("update_pulses", upd_cnt, 5);
        check("hand_valid", valid, 1);

        // Short glitch on HEX1 must not be accepted.
        HEX1 = P_5;
        tick(6);
        HEX1 = P_K;
        upd_cnt = 0;
        tick(24);
        check("glitch_pcard2", pcard2_out, 13);
        check("glitch_no_update", upd_cnt, 0);
        check("glitch_valid", valid, 1);

        // Invalid pattern on HEX4.
        HEX4 = P_BAD;
        tick(30);
`ifdef SEG7DEC_ERRCHK_EN
        check("bad_dcard2", dcard2_out, 15);
        check("bad_err", err, 1);
        check("bad_err_digit", err_digit, 4);
        check("bad_valid", valid, 0);
`else
        check("bad_dcard2", dcard2_out, 0);
        check("bad_err", err, 0);
        check("bad_err_digit", err_digit, 0);
        check("bad_valid", valid, 1);
`endif
        check("bad_dscore", dscore_out, 9);
        HEX4 = P_9;
        tick(30);
        check("restored_dcard2", dcard2_out, 9);
`ifdef SEG7DEC_ERRCHK_EN
        check("sticky_err", err, 1);
        check("sticky_err_digit", err_digit, 4);
        check("sticky_valid", valid, 0);
`else
        check("sticky_err", err, 0);
        check("sticky_valid", valid, 1);
`endif

        // Reset mid-operation clears everything on that edge.
        reset = 1'b1;
        @(negedge clk);
        check("midrst_pcard1", pcard1_out, 0);
        check("midrst_dcard1", dcard1_out, 0);
        check("midrst_pscore", pscore_out, 0);
        check("midrst_valid", valid, 0);
        check("midrst_err", err, 0);
        reset = 1'b0;

        // Reset at cycle 10 of acquisition, then full relatency.
        tick(10);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("acqrst_valid", valid, 0);
        tick(18);
        check("reacq_valid_c17", valid, 0);
        tick(1);
        check("reacq_valid_c18", valid, 1);
        check("reacq_pcard1", pcard1_out, 1);
        check("reacq_dscore", dscore_out, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
